// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decoder/branch-resolution signals.
// The master modport is the fetch unit; the slave modport is memory, decoder and ALU together.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic              instr_valid;
    logic              stall;
    logic [1:0]        branch;
    logic              alu_zero;
    logic [31:0]       branch_offset;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
        input  imem_rdata, imem_ready, stall, branch, alu_zero, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4,
        output imem_rdata, imem_ready, stall, branch, alu_zero, branch_offset
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over req/ready and resolves BEQ/BNE next-PC.
// Optional FETCH_JUMP_EN makes opcode 2 (J) override branch resolution in ISSUE.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | imem_req high at pc, wait for imem_ready, then latch instr
// ISSUE | instr/opcode/pc presented to decoder; leave when stall is low
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic {FETCH, ISSUE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              valid_q;

    logic              taken;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        pc_plus4  = pc_q + ADDR_W'(4);
        taken     = (bus.branch == 2'b11 && bus.alu_zero) ||
                    (bus.branch == 2'b01 && !bus.alu_zero);
        // Offset is a word count; the sum wraps silently at 2^ADDR_W.
        br_target = pc_plus4 + ADDR_W'(bus.branch_offset << 2);
        pc_next   = taken ? br_target : pc_plus4;
`ifdef FETCH_JUMP_EN
        if (instr_q[31:26] == 6'd2)
            pc_next = {pc_plus4[ADDR_W-1:28], instr_q[25:0], 2'b00};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.stall) begin
                        pc_q    <= pc_next;
                        valid_q <= 1'b0;
                        state   <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Request is gated by reset so nothing is asked of memory during a reset cycle.
    assign bus.imem_req    = (state == FETCH) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
endmodule
